// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and sizing helpers for the delay-line controller slice.
package delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int dly_w(input int stage);
        return $clog2(stage + 1);
    endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Stream and control bundle between the delay-line controller and its producer/consumer.
interface delay_line_ctrl_if
    import delay_line_pkg::*;
#(
    parameter int STAGE = 4,
    parameter int WIDTH = 8
) ();

    localparam int DLY_W = dly_w(STAGE);

    logic             start;
    logic [DLY_W-1:0] cfg_delay;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;

    modport master (
        output start, cfg_delay, flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, cfg_delay, flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/delay_line_ctrl_shift_reg_en.sv
// Enable-gated shift chain with a parallel per-stage valid vector; every stage is visible.
module shift_reg_en #(
    parameter int STAGE = 4,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        shift,
    input  logic                        push_valid,
    input  logic [WIDTH-1:0]            push_data,
    output logic [STAGE-1:0][WIDTH-1:0] stage_data,
    output logic [STAGE-1:0]            stage_vld
);

    logic [STAGE-1:0][WIDTH-1:0] data_r;
    logic [STAGE-1:0]            vld_r;

    // Data stages carry no reset; their validity is tracked separately in vld_r.
    always_ff @(posedge clk) begin
        if (shift) begin
            data_r[0] <= push_data;
            for (int i = 1; i < STAGE; i++) begin
                data_r[i] <= data_r[i-1];
            end
        end
    end

    // Valid vector shifts alongside the data and is wiped at session start.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_r <= {STAGE{1'b0}};
        end else if (shift) begin
            vld_r[0] <= push_valid;
            for (int i = 1; i < STAGE; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    assign stage_data = data_r;
    assign stage_vld  = vld_r;

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequencing controller for a programmable-depth delay line: fill to D, stream paired
// push/pop beats, then drain on command.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int STAGE = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    delay_line_ctrl_if.slave bus
);

    localparam int               DLY_W = dly_w(STAGE);
    localparam logic [DLY_W-1:0] D_MIN = DLY_W'(1);
    localparam logic [DLY_W-1:0] D_MAX = DLY_W'(STAGE);
    localparam logic [DLY_W-1:0] D_ZERO = {DLY_W{1'b0}};

    state_t                      state_r, state_s;
    logic [DLY_W-1:0]            d_r;
    logic [DLY_W-1:0]            cnt_r, cnt_s;
    logic [DLY_W-1:0]            d_clamp_s;
    logic [DLY_W-1:0]            tap_idx_s;
    logic                        shift_s, push_valid_s, clr_s;
    logic [WIDTH-1:0]            push_data_s;
    logic                        in_ready_s, out_valid_s, done_s;
    logic [STAGE-1:0][WIDTH-1:0] stage_data_s;
    logic [STAGE-1:0]            stage_vld_s;
    logic [WIDTH-1:0]            tap_data_s;
    logic                        tap_vld_s;
    logic                        live_s;
    logic                        rest_s;

    shift_reg_en #(
        .STAGE (STAGE),
        .WIDTH (WIDTH)
    ) u_chain (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_s),
        .shift      (shift_s),
        .push_valid (push_valid_s),
        .push_data  (push_data_s),
        .stage_data (stage_data_s),
        .stage_vld  (stage_vld_s)
    );

    assign d_clamp_s = (bus.cfg_delay == D_ZERO) ? D_MIN :
                       ((bus.cfg_delay > D_MAX) ? D_MAX : bus.cfg_delay);
    assign tap_idx_s = d_r - D_MIN;

    // Tap D-1 select; live_s = any word still in the active window, rest_s = any below the tap.
    always_comb begin
        tap_data_s = {WIDTH{1'b0}};
        tap_vld_s  = 1'b0;
        live_s     = 1'b0;
        rest_s     = 1'b0;
        for (int i = 0; i < STAGE; i++) begin
            tap_data_s = (DLY_W'(i) == tap_idx_s) ? stage_data_s[i] : tap_data_s;
            tap_vld_s  = (DLY_W'(i) == tap_idx_s) ? stage_vld_s[i]  : tap_vld_s;
            live_s     = live_s | (stage_vld_s[i] & (DLY_W'(i) < d_r));
            rest_s     = rest_s | (stage_vld_s[i] & (DLY_W'(i) < tap_idx_s));
        end
    end

    // Next-state, chain control and handshake decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shift_s      = 1'b0;
        push_valid_s = 1'b0;
        clr_s        = 1'b0;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = FILL;
                    cnt_s   = D_ZERO;
                    clr_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                in_ready_s   = 1'b1;
                shift_s      = bus.in_valid;
                push_valid_s = bus.in_valid;
                cnt_s        = bus.in_valid ? (cnt_r + D_MIN) : cnt_r;
                // A word accepted alongside flush still lands before the drain starts.
                if (bus.flush) begin
                    if (bus.in_valid || (cnt_r != D_ZERO)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
                end else if (bus.in_valid && ((cnt_r + D_MIN) == d_r)) begin
                    state_s = RUN;
                end else begin
                    state_s = FILL;
                end
            end
            RUN: begin
                out_valid_s  = bus.in_valid;
                in_ready_s   = bus.out_ready;
                shift_s      = bus.in_valid & bus.out_ready;
                push_valid_s = bus.in_valid & bus.out_ready;
                state_s      = bus.flush ? DRAIN : RUN;
            end
            DRAIN: begin
                out_valid_s = tap_vld_s;
                shift_s     = live_s & (~tap_vld_s | bus.out_ready);
                if (!live_s || (shift_s && !rest_s)) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign push_data_s = push_valid_s ? bus.in_data : {WIDTH{1'b0}};

    // Controller state, delay register and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= D_ZERO;
            d_r     <= D_MIN;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if ((state_r == IDLE) && bus.start) begin
                d_r <= d_clamp_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_valid_s ? tap_data_s : {WIDTH{1'b0}};
    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_s & ~rst;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed plus randomized bench for delay_line_ctrl against a queue-based session model.
module tb_delay_line_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    delay_line_ctrl_if #(.STAGE(4), .WIDTH(8)) bus ();

    delay_line_ctrl #(.STAGE(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: session phase, words currently held (oldest first), delay, pending bubbles.
    int         m_mode = 0; // 0 idle, 1 fill, 2 run, 3 drain
    logic [7:0] m_q[$];
    int         m_d = 1;
    int         m_bub = 0;

    logic [31:0] s_ov, s_ir, s_data, s_done, s_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit st, input int cfg, input bit fl, input bit iv,
                          input logic [7:0] d, input bit ordy);
        bus.start     = st;
        bus.cfg_delay = 3'(cfg);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic model_update();
        int c;
        if (rst) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    c = int'(bus.cfg_delay);
                    m_d = (c == 0) ? 1 : ((c > 4) ? 4 : c);
                    m_q.delete();
                    m_mode = 1;
                end
                1: begin
                    if (bus.in_valid) m_q.push_back(bus.in_data);
                    if (bus.flush) begin
                        if (m_q.size() > 0) begin
                            m_mode = 3;
                            m_bub = m_d - m_q.size();
                        end else begin
                            m_mode = 0;
                        end
                    end else if (m_q.size() == m_d) begin
                        m_mode = 2;
                    end
                end
                2: begin
                    if (bus.in_valid && bus.out_ready) begin
                        void'(m_q.pop_front());
                        m_q.push_back(bus.in_data);
                    end
                    if (bus.flush) begin
                        m_mode = 3;
                        m_bub = 0;
                    end
                end
                3: begin
                    if (m_bub > 0) begin
                        m_bub--;
                    end else if (bus.out_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_mode = 0;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cyc();
        logic p_ir, p_ov, p_done;
        logic [7:0] p_data;
        @(negedge clk);
        p_ir = 1'b0; p_ov = 1'b0; p_done = 1'b0; p_data = 8'h00;
        case (m_mode)
            1: begin
                p_ir = 1'b1;
                p_done = bus.flush && !bus.in_valid && (m_q.size() == 0);
            end
            2: begin
                p_ov = bus.in_valid;
                p_ir = bus.out_ready;
            end
            3: begin
                p_ov = (m_bub == 0) && (m_q.size() > 0);
                p_done = (m_bub == 0) && bus.out_ready && (m_q.size() == 1);
            end
            default: ;
        endcase
        if (p_ov) p_data = m_q[0];
        if (rst) p_done = 1'b0;
        s_ov = 32'(bus.out_valid); s_ir = 32'(bus.in_ready); s_data = 32'(bus.out_data);
        s_done = 32'(bus.done); s_busy = 32'(bus.busy);
        chk("in_ready", s_ir, 32'(p_ir));
        chk("out_valid", s_ov, 32'(p_ov));
        chk("out_data", s_data, 32'(p_data));
        chk("done", s_done, 32'(p_done));
        chk("busy", s_busy, 32'(m_mode != 0));
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_out(input string tag);
        set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (s_done == 32'd1) break;
        end
        chk({tag, "_done_seen"}, s_done, 32'd1);
        cyc();
        chk({tag, "_idle"}, s_busy, 32'd0);
    endtask

    initial begin
        set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cyc();
        chk("rst_out_valid", s_ov, 32'd0);
        chk("rst_busy", s_busy, 32'd0);
        rst = 1'b0;

        // D=3 fill, first output, beat, then back-pressure hold
        set_in(1'b1, 3, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h11, 1'b0); cyc();
        chk("s1_fill_ready", s_ir, 32'd1);
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h22, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h33, 1'b0); cyc();
        chk("s1_no_early_out", s_ov, 32'd0);
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h44, 1'b0); cyc();
        chk("s1_first_valid", s_ov, 32'd1);
        chk("s1_first_data", s_data, 32'h11);
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h44, 1'b1); cyc();
        chk("s1_beat_data", s_data, 32'h11);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 0, 1'b0, 1'b1, 8'h55, 1'b0); cyc();
            chk("s2_stall_ready", s_ir, 32'd0);
            chk("s2_stall_data", s_data, 32'h22);
        end
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h55, 1'b1); cyc();
        chk("s2_release_data", s_data, 32'h22);

        // flush from RUN with three words resident
        set_in(1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b1); cyc();
        set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1); cyc();
        chk("s3_d0", s_data, 32'h33);
        cyc();
        chk("s3_d1", s_data, 32'h44);
        chk("s3_no_early_done", s_done, 32'd0);
        cyc();
        chk("s3_d2", s_data, 32'h55);
        chk("s3_done", s_done, 32'd1);
        cyc();
        chk("s3_busy_low", s_busy, 32'd0);
        chk("s3_done_once", s_done, 32'd0);

        // D=4 partial fill then flush: two bubble shifts first
        set_in(1'b1, 4, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'hA1, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'hA2, 1'b0); cyc();
        set_in(1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b1); cyc();
        set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1); cyc();
        chk("s4_bubble0", s_ov, 32'd0);
        cyc();
        chk("s4_bubble1", s_ov, 32'd0);
        cyc();
        chk("s4_a1", s_data, 32'hA1);
        cyc();
        chk("s4_a2", s_data, 32'hA2);
        chk("s4_done", s_done, 32'd1);
        cyc();

        // cfg_delay=0 behaves as D=1
        set_in(1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h5A, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'h5B, 1'b0); cyc();
        chk("s5_d1_valid", s_ov, 32'd1);
        chk("s5_d1_data", s_data, 32'h5A);
        set_in(1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0); cyc();
        drain_out("s5_d1");

        // cfg_delay=7 behaves as D=4
        set_in(1'b1, 7, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 0, 1'b0, 1'b1, 8'(8'hC1 + i), 1'b0); cyc();
            chk("s5_d4_filling", s_ir, 32'd1);
        end
        set_in(1'b0, 0, 1'b0, 1'b1, 8'hC5, 1'b0); cyc();
        chk("s5_d4_data", s_data, 32'hC1);
        set_in(1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b1); cyc();
        drain_out("s5_d4");

        // rst mid-DRAIN, then a clean D=2 session
        set_in(1'b1, 3, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 0, 1'b0, 1'b1, 8'(8'hD1 + i), 1'b0); cyc();
        end
        set_in(1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        chk("s6_drain_hold", s_data, 32'hD1);
        rst = 1'b1; set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1); cyc();
        rst = 1'b0; set_in(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1); cyc();
        chk("s6_rst_ov", s_ov, 32'd0);
        chk("s6_rst_done", s_done, 32'd0);
        chk("s6_rst_busy", s_busy, 32'd0);
        set_in(1'b1, 2, 1'b0, 1'b0, 8'h00, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'hE1, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'hE2, 1'b0); cyc();
        set_in(1'b0, 0, 1'b0, 1'b1, 8'hE3, 1'b0); cyc();
        chk("s6_fresh_data", s_data, 32'hE1);
        set_in(1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b1); cyc();
        drain_out("s6");

        // randomized sessions, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                   8'($urandom), ($urandom_range(0, 2) != 0));
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencing controller for a programmable-depth shift-register delay line. It accepts a valid/ready input stream, fills the chain to a run-time delay D, then streams paired push/pop beats so that each output word is the input from D beats earlier. On command it drains the remaining words and returns to idle. It sits between a streaming producer and consumer wherever a fixed sample delay is needed without stalling the pipeline on back-pressure.

## Interface
- STAGE, 4, maximum delay depth (≥1)
- WIDTH, 8, data word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begin a session (honoured only in IDLE)
- cfg_delay  in  $clog2(STAGE+1)  requested delay D, sampled on accepted start
- flush  in  1  pulse; end session and drain (honoured in FILL/RUN)
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  WIDTH  input word
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  WIDTH  oldest word (tap D-1); 0 when out_valid=0
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on DRAIN→IDLE

## Operation
- Clock is clk. Reset is rst: synchronous, active-high.
- Effective D = clamp(cfg_delay, 1, STAGE); latched in a register on start.
- Chain: STAGE data stages plus per-stage valid bit vld[]. A shift pushes (data, 1) or bubble (0, 0) into stage 0 and moves every stage up by one.
- IDLE: in_ready=0, out_valid=0. start → FILL, fill count=0, vld cleared.
- FILL: in_ready=1, out_valid=0. Each accepted word shifts in with vld=1 and increments count; accepting the D-th word → RUN.
- RUN: out_valid=in_valid, in_ready=out_ready; a beat (in_valid & out_ready) pops tap D-1 and pushes in_data in the same shift. No shift without a beat.
- flush in FILL or RUN → DRAIN; a beat in the same cycle completes first. flush in FILL with count=0 → IDLE with a done pulse.
- DRAIN: in_ready=0, out_valid=vld[D-1]. Bubbles shift in whenever !vld[D-1] or out_ready, and only while any vld[0..D-1] is set. When the shift empties the last valid → IDLE, done=1 for one cycle.
- start outside IDLE and flush in IDLE/DRAIN are ignored.

## Timing
- Reset values: state IDLE, in_ready 0, out_valid 0, out_data 0, busy 0, done 0, vld all 0, count 0. Data stages are not reset.
- rst mid-session aborts immediately: the next cycle is IDLE, no done pulse.
- in_ready, out_valid and out_data are combinational from registered state, vld, and the current-cycle handshake inputs. RUN has combinational paths in_valid→out_valid and out_ready→in_ready; the consumer must not make out_ready depend on out_valid.
- Latency: a word accepted on beat n appears on out_data at beat n+D. The first out_valid is the cycle after the D-th FILL accept.
- Drain with k valid words at positions p needs (D-1-p_max) bubble shifts before the first output. It ends ≤ D + stall cycles after flush.
- busy=1 from the cycle after start until the cycle done is asserted, inclusive.

## Structure
- Package delay_line_pkg: state enum {IDLE, FILL, RUN, DRAIN} and a DLY_W = $clog2(STAGE+1) helper function.
- Sub-module shift_reg_en: enable-gated STAGE×WIDTH chain with a parallel valid vector and inputs shift, push_valid, push_data. It exposes all stages so the controller can mux tap D-1.
- Controller: FSM, D register, fill counter, tap mux and handshake logic.

## Test plan
(All scenarios use STAGE=4, WIDTH=8.)
- start, cfg_delay=3; push 0x11,0x22,0x33 → out_valid rises the next cycle with out_data=0x11. Then push 0x44 with out_ready=1 → 0x11 consumed, out_data=0x22.
- RUN with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0, no shift, out_data held at 0x22.
- D=3 after 0x11..0x55 pushed (0x11, 0x22 popped), flush with out_ready=1 → outputs 0x33, 0x44, 0x55 on consecutive cycles, done pulses once, busy=0.
- D=4, push 0xA1, 0xA2, flush → two bubble shifts with out_valid=0, then 0xA1, 0xA2, then done.
- cfg_delay=0 → behaves as D=1 (first output after 1 push). cfg_delay=7 → behaves as D=4.
- rst asserted mid-DRAIN → next cycle IDLE, out_valid=0, done=0. A new start with D=2 then fills cleanly, with no stale words emitted.
